// File: rtl/endat_slave.sv
// EnDat-style encoder-side responder.
// Oversamples the master clock on enc_clk, captures the 6-bit mode command and,
// on a position request, returns start bit, F1, F2, the position word (MSB first)
// and a CRC-5 over F1/F2/position.
//
// Ports:
//   enc_clk     free-running local clock (rising edge)
//   rst_n       asynchronous active-low reset
//   ma_clk      master clock, idles high, asynchronous
//   ma_data_in  command data from the master
//   pos_in      position, LSB-aligned; low pos_width bits are sent
//   pos_width   position bit count 1..40 (anything else means 40)
//   alarm/warn  sent as F1/F2
//   sl_data     serial data to the master
//   sl_de       line drive enable (1 = slave drives sl_data)
//   cmd_out     last captured command, cmd_valid pulses when it updates
//   cmd_err     pulse when the command is not a position request
//   frame_done  pulse after the last CRC bit
//   frame_err   pulse on a mid-frame timeout abort
//   busy        high in every state except READY
//
// state    | meaning
// ---------+-----------------------------------------------------------
// READY    | idle, line driven low, waiting for the frame-start fall
// HDR      | counting tST edges and shifting in the mode command
// TURN     | two turnaround clocks before the start bit
// XMIT     | one bit per ma_clk fall: F1, F2, position, CRC
// WAIT     | bad command, line released until the idle timeout
// RECOVERY | line driven high until ma_clk has been quiet long enough

module endat_slave #(
    parameter logic [5:0] CMD_POS      = 6'b000111,
    parameter logic [4:0] CRC_POLY     = 5'b01001,
    parameter int         TIMEOUT_CYC  = 1024,
    parameter int         RECOVERY_CYC = 64
) (
    input  logic        enc_clk,
    input  logic        rst_n,
    input  logic        ma_clk,
    input  logic        ma_data_in,
    input  logic [39:0] pos_in,
    input  logic [5:0]  pos_width,
    input  logic        alarm,
    input  logic        warn,
    output logic        sl_data,
    output logic        sl_de,
    output logic [5:0]  cmd_out,
    output logic        cmd_valid,
    output logic        cmd_err,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);
    localparam int TMR_MAX = (TIMEOUT_CYC > RECOVERY_CYC) ? TIMEOUT_CYC : RECOVERY_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] REC_LOAD = TMR_W'(RECOVERY_CYC - 1);

    typedef enum logic [2:0] {READY, HDR, TURN, XMIT, WAIT, RECOVERY} state_t;

    state_t            state_q, state_d;
    logic              clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
    logic              ma_rise, ma_fall, ma_edge, tmr_tc;
    logic [3:0]        r_q, r_d, r_inc;
    logic [5:0]        cmd_q, cmd_d, cmd_shift, cmd_out_q, cmd_out_d;
    logic [39:0]       pos_q, pos_d;
    logic [5:0]        width_q, width_d, w_eff;
    logic [6:0]        seq_q, seq_d, w_ext;
    logic              f1_q, f1_d, f2_q, f2_d, tx_bit;
    logic [4:0]        crc_q, crc_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              sl_data_q, sl_data_d, sl_de_q, sl_de_d;
    logic              cmd_valid_d, cmd_err_d, frame_done_d, frame_err_d;
    logic              cmd_valid_q, cmd_err_q, frame_done_q, frame_err_q;

    // ma_clk syncs reset to 1 so the idle-high line does not look like an edge.
    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
        end else begin
            clk_s1 <= ma_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ma_data_in;
            dat_s2 <= dat_s1;
        end
    end

    assign ma_rise = clk_s2 & ~clk_s3;
    assign ma_fall = ~clk_s2 & clk_s3;
    assign ma_edge = clk_s2 ^ clk_s3;
    assign tmr_tc  = ~ma_edge && (timer_q == '0);
    assign w_eff   = (pos_width == 6'd0 || pos_width > 6'd40) ? 6'd40 : pos_width;
    assign w_ext   = {1'b0, width_q};

    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= READY;
            r_q          <= '0;
            cmd_q        <= '0;
            cmd_out_q    <= '0;
            pos_q        <= '0;
            width_q      <= '0;
            seq_q        <= '0;
            f1_q         <= 1'b0;
            f2_q         <= 1'b0;
            crc_q        <= '0;
            timer_q      <= '0;
            sl_data_q    <= 1'b0;
            sl_de_q      <= 1'b1;
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            cmd_q        <= cmd_d;
            cmd_out_q    <= cmd_out_d;
            pos_q        <= pos_d;
            width_q      <= width_d;
            seq_q        <= seq_d;
            f1_q         <= f1_d;
            f2_q         <= f2_d;
            crc_q        <= crc_d;
            timer_q      <= timer_d;
            sl_data_q    <= sl_data_d;
            sl_de_q      <= sl_de_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_err_q    <= cmd_err_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        cmd_d        = cmd_q;
        cmd_out_d    = cmd_out_q;
        pos_d        = pos_q;
        width_d      = width_q;
        seq_d        = seq_q;
        f1_d         = f1_q;
        f2_d         = f2_q;
        crc_d        = crc_q;
        sl_data_d    = sl_data_q;
        sl_de_d      = sl_de_q;
        cmd_valid_d  = 1'b0;
        cmd_err_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        r_inc        = r_q + 4'd1;
        cmd_shift    = {cmd_q[4:0], dat_s2};
        tx_bit       = 1'b0;

        // Watchdog down-counter: any ma_clk edge reloads it for the current phase.
        if (ma_edge)
            timer_d = (state_q == RECOVERY) ? REC_LOAD : TO_LOAD;
        else if (timer_q != '0)
            timer_d = timer_q - 1'b1;
        else
            timer_d = timer_q;

        case (state_q)
            READY: begin
                sl_de_d   = 1'b1;
                sl_data_d = 1'b0;
                if (ma_fall) begin
                    state_d   = HDR;
                    sl_de_d   = 1'b0;
                    r_d       = '0;
                    cmd_d     = '0;
                    crc_d     = '0;
                    f1_d      = alarm;
                    f2_d      = warn;
                    width_d   = w_eff;
                    // Left-justify so the first position bit is always pos_q[39].
                    pos_d     = pos_in << (6'd40 - w_eff);
                    timer_d   = TO_LOAD;
                end
            end
            HDR: begin
                if (ma_rise) begin
                    r_d = r_inc;
                    if (r_inc >= 4'd3)
                        cmd_d = cmd_shift;
                    if (r_inc == 4'd8) begin
                        cmd_out_d   = cmd_shift;
                        cmd_valid_d = 1'b1;
                        if (cmd_shift == CMD_POS) begin
                            state_d = TURN;
                        end else begin
                            cmd_err_d = 1'b1;
                            state_d   = WAIT;
                        end
                    end
                end else if (tmr_tc) begin
                    state_d     = RECOVERY;
                    frame_err_d = 1'b1;
                    sl_de_d     = 1'b1;
                    sl_data_d   = 1'b1;
                    timer_d     = REC_LOAD;
                end
            end
            TURN: begin
                if (ma_rise) begin
                    r_d = r_inc;
                end else if (ma_fall && r_q == 4'd10) begin
                    state_d   = XMIT;
                    sl_de_d   = 1'b1;
                    sl_data_d = 1'b1;
                    seq_d     = '0;
                end else if (tmr_tc) begin
                    state_d     = RECOVERY;
                    frame_err_d = 1'b1;
                    sl_de_d     = 1'b1;
                    sl_data_d   = 1'b1;
                    timer_d     = REC_LOAD;
                end
            end
            XMIT: begin
                // seq: 0 = F1, 1 = F2, 2..w+1 = position, w+2..w+6 = CRC, w+7 = stop
                if (ma_fall) begin
                    seq_d = seq_q + 7'd1;
                    if (seq_q < w_ext + 7'd2) begin
                        if (seq_q == 7'd0)
                            tx_bit = f1_q;
                        else if (seq_q == 7'd1)
                            tx_bit = f2_q;
                        else begin
                            tx_bit = pos_q[39];
                            pos_d  = {pos_q[38:0], 1'b0};
                        end
                        sl_data_d = tx_bit;
                        crc_d = {crc_q[3:0], 1'b0} ^ ((crc_q[4] ^ tx_bit) ? CRC_POLY : 5'b0);
                    end else if (seq_q < w_ext + 7'd7) begin
                        sl_data_d = crc_q[4];
                        crc_d     = {crc_q[3:0], 1'b0};
                    end else begin
                        state_d      = RECOVERY;
                        sl_data_d    = 1'b1;
                        frame_done_d = 1'b1;
                        timer_d      = REC_LOAD;
                    end
                end else if (tmr_tc) begin
                    state_d     = RECOVERY;
                    frame_err_d = 1'b1;
                    sl_de_d     = 1'b1;
                    sl_data_d   = 1'b1;
                    timer_d     = REC_LOAD;
                end
            end
            WAIT: begin
                // Bad command: stay off the line, leave quietly on timeout.
                if (tmr_tc) begin
                    state_d   = RECOVERY;
                    sl_de_d   = 1'b1;
                    sl_data_d = 1'b1;
                    timer_d   = REC_LOAD;
                end
            end
            RECOVERY: begin
                sl_de_d   = 1'b1;
                sl_data_d = 1'b1;
                if (tmr_tc) begin
                    state_d   = READY;
                    sl_data_d = 1'b0;
                end
            end
            default: begin
                state_d   = READY;
                sl_de_d   = 1'b1;
                sl_data_d = 1'b0;
            end
        endcase
    end

    assign sl_data    = sl_data_q;
    assign sl_de      = sl_de_q;
    assign cmd_out    = cmd_out_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_err    = cmd_err_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != READY);

endmodule
